// File: rtl/ctl_pkg.sv
// Shared decode constants and the EX control bundle for the
// ID->EX control pipe (decoder, hazard logic, HI/LO sequencer).
package ctl_pkg;

  localparam int CNT_W = 6;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_SLT  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00101;
  localparam logic [4:0] ALU_XOR  = 5'b00110;
  localparam logic [4:0] ALU_SLTU = 5'b01001;
  localparam logic [4:0] ALU_LINK = 5'b01010;
  localparam logic [4:0] ALU_LUI  = 5'b10000;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_GEZ  = 3'd3,
    BR_LTZ  = 3'd4,
    BR_GTZ  = 3'd5,
    BR_LEZ  = 3'd6
  } br_kind_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    logic     mem_to_reg;
    logic     alu_src;
    logic     ext_op;
    logic     jmp;
    logic     jal;
    br_kind_e br_kind;
    logic     mem_byte;
    logic     mem_unsigned;
    logic     md_start;
    logic     md_sel_hi;
    logic     illegal;
  } ctl_t;

  localparam int CTL_W = $bits(ctl_t);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/ctl_dec.sv
// Combinational instruction decoder: control flags, aluop,
// destination register and operand-use hints for hazard checks.
module ctl_dec
  import ctl_pkg::*;
#(
  parameter int ALUOP_W = 5
) (
  input  logic [31:0]        i_instr,
  output ctl_t               o_ctl,
  output logic [ALUOP_W-1:0] o_aluop,
  output logic [4:0]         o_wreg,
  output logic               o_rd_rt,
  output logic               o_md_use
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic [4:0] w_wr;
  logic [4:0] w_alu;
  logic       w_unused;

  assign w_op     = i_instr[31:26];
  assign w_rt     = i_instr[20:16];
  assign w_rd     = i_instr[15:11];
  assign w_fn     = i_instr[5:0];
  assign w_unused = ^{i_instr[25:21], i_instr[10:6]};

  always_comb begin
    o_ctl    = '0;
    w_alu    = ALU_ADD;
    w_wr     = w_rt;
    o_rd_rt  = 1'b0;
    o_md_use = 1'b0;
    unique case (w_op)
      OP_RTYPE: begin
        o_rd_rt         = 1'b1;
        w_wr            = w_rd;
        o_ctl.reg_write = 1'b1;
        unique case (w_fn)
          FN_ADD, FN_ADDU: w_alu = ALU_ADD;
          FN_SUB, FN_SUBU: w_alu = ALU_SUB;
          FN_AND:  w_alu = ALU_AND;
          FN_OR:   w_alu = ALU_OR;
          FN_XOR:  w_alu = ALU_XOR;
          FN_SLT:  w_alu = ALU_SLT;
          FN_SLTU: w_alu = ALU_SLTU;
          FN_MFHI: begin
            o_md_use        = 1'b1;
            o_ctl.md_sel_hi = 1'b1;
          end
          FN_MFLO: o_md_use = 1'b1;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            o_md_use        = 1'b1;
            o_ctl.reg_write = 1'b0;
            o_ctl.md_start  = 1'b1;
          end
          default: begin
            o_ctl.reg_write = 1'b0;
            o_ctl.illegal   = 1'b1;
          end
        endcase
      end
      OP_REGIMM: begin
        unique case (w_rt)
          RT_BGEZ: begin
            o_ctl.br_kind = BR_GEZ;
            w_alu         = ALU_SUB;
          end
          RT_BLTZ: begin
            o_ctl.br_kind = BR_LTZ;
            w_alu         = ALU_SUB;
          end
          default: o_ctl.illegal = 1'b1;
        endcase
      end
      OP_BEQ: begin
        o_rd_rt       = 1'b1;
        o_ctl.br_kind = BR_EQ;
        w_alu         = ALU_SUB;
      end
      OP_BNE: begin
        o_rd_rt       = 1'b1;
        o_ctl.br_kind = BR_NE;
        w_alu         = ALU_SUB;
      end
      OP_BGTZ: begin
        o_ctl.br_kind = BR_GTZ;
        w_alu         = ALU_SUB;
      end
      OP_BLEZ: begin
        o_ctl.br_kind = BR_LEZ;
        w_alu         = ALU_SUB;
      end
      OP_J: o_ctl.jmp = 1'b1;
      OP_JAL: begin
        o_ctl.jmp       = 1'b1;
        o_ctl.jal       = 1'b1;
        o_ctl.reg_write = 1'b1;
        w_wr            = 5'd31;
        w_alu           = ALU_LINK;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        o_ctl.reg_write = 1'b1;
        o_ctl.alu_src   = 1'b1;
        o_ctl.ext_op    = 1'b1;
        w_alu = (w_op == OP_SLTI)  ? ALU_SLT  :
                (w_op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        o_ctl.reg_write = 1'b1;
        o_ctl.alu_src   = 1'b1;
        w_alu = (w_op == OP_ANDI) ? ALU_AND :
                (w_op == OP_ORI)  ? ALU_OR  :
                (w_op == OP_XORI) ? ALU_XOR : ALU_LUI;
      end
      OP_LW, OP_LB, OP_LBU: begin
        o_ctl.reg_write    = 1'b1;
        o_ctl.mem_to_reg   = 1'b1;
        o_ctl.alu_src      = 1'b1;
        o_ctl.ext_op       = 1'b1;
        o_ctl.mem_byte     = (w_op != OP_LW);
        o_ctl.mem_unsigned = (w_op == OP_LBU);
      end
      OP_SW, OP_SB: begin
        o_rd_rt         = 1'b1;
        o_ctl.mem_write = 1'b1;
        o_ctl.alu_src   = 1'b1;
        o_ctl.ext_op    = 1'b1;
        o_ctl.mem_byte  = (w_op == OP_SB);
      end
      default: o_ctl.illegal = 1'b1;
    endcase
  end

  assign o_aluop = ALUOP_W'(w_alu);
  assign o_wreg  = o_ctl.reg_write ? w_wr : 5'd0;

endmodule

// File: rtl/ctl_pipe.sv
// ID->EX control pipe: load-use and HI/LO hazard stalls, flush,
// the EX control register and the MULT/DIV occupancy sequencer.
module ctl_pipe
  import ctl_pkg::*;
#(
  parameter int MD_LAT  = 32,
  parameter int ALUOP_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [31:0]              id_instr,
  input  logic                     flush,
  output logic                     id_ready,
  output logic                     ex_valid,
  output logic [CTL_W+ALUOP_W-1:0] ex_ctl,
  output logic [4:0]               ex_wreg,
  output logic                     md_busy,
  output logic                     md_done
);

  ctl_t               w_ctl;
  logic [ALUOP_W-1:0] w_alu;
  logic [4:0]         w_wreg;
  logic               w_rd_rt;
  logic               w_md_use;
  logic [4:0]         w_rs;
  logic [4:0]         w_rt;
  logic               w_lu_hit;
  logic               w_md_hit;
  logic               w_stall;
  logic               w_acc;
  logic               w_md_go;

  ctl_t               r_ctl;
  logic [ALUOP_W-1:0] r_alu;
  logic [4:0]         r_wreg;
  logic               r_valid;

  md_state_e          r_st;
  md_state_e          w_st_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nx;

  ctl_dec #(
    .ALUOP_W (ALUOP_W)
  ) u_dec (
    .i_instr  (id_instr),
    .o_ctl    (w_ctl),
    .o_aluop  (w_alu),
    .o_wreg   (w_wreg),
    .o_rd_rt  (w_rd_rt),
    .o_md_use (w_md_use)
  );

  assign w_rs = id_instr[25:21];
  assign w_rt = id_instr[20:16];

  assign w_lu_hit = r_valid && r_ctl.mem_to_reg
                 && (r_wreg != 5'd0)
                 && ((r_wreg == w_rs)
                  || (w_rd_rt && (r_wreg == w_rt)));
  assign w_md_hit = (r_st == MD_BUSY) && w_md_use;
  assign w_stall  = id_valid && (w_lu_hit || w_md_hit);

  // Flush discards the ID word, so it is consumed but never enters EX.
  assign w_acc    = rst_n && id_valid && !flush && !w_stall;
  assign id_ready = rst_n && (flush || !w_stall);
  assign w_md_go  = w_acc && w_ctl.md_start;

  assign md_busy  = (r_st == MD_BUSY) || w_md_go;
  assign md_done  = (r_st == MD_BUSY) && (r_cnt == '0);

  always_comb begin
    w_st_nx  = r_st;
    w_cnt_nx = r_cnt;
    unique case (r_st)
      MD_IDLE: begin
        if (w_md_go) begin
          w_st_nx  = MD_BUSY;
          w_cnt_nx = CNT_W'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (r_cnt == '0) w_st_nx = MD_IDLE;
        else w_cnt_nx = r_cnt - CNT_W'(1);
      end
      default: w_st_nx = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= MD_IDLE;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nx;
      r_cnt <= w_cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctl   <= '0;
      r_alu   <= '0;
      r_wreg  <= '0;
    end else begin
      r_valid <= w_acc;
      r_ctl   <= w_acc ? w_ctl : '0;
      r_alu   <= w_acc ? w_alu : '0;
      r_wreg  <= w_acc ? w_wreg : '0;
    end
  end

  assign ex_valid = r_valid;
  assign ex_ctl   = {r_ctl, r_alu};
  assign ex_wreg  = r_wreg;

endmodule
